// File: rtl/trap_sequencer.sv
// Writeback-stage sequencer: retire / trap / mret decision, Zicsr read-modify-write, fetch redirect.
// Optional interrupt arbitration enabled by defining TRAP_SEQUENCER_IRQ_EN.
module trap_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [5:0]  in_exc,
    input  logic        in_mret,
    input  logic        in_is_csr,
    input  logic [2:0]  in_csr_op,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rs1_idx,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_csr_old,
    input  logic        in_csr_writeable,
    input  logic [2:0]  irq,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mret_vector,
    output logic        write_enable,
    output logic [11:0] write_address,
    output logic [31:0] write_data,
    output logic        retired,
    output logic        traped,
    output logic        mret,
    output logic [31:0] ecp,
    output logic [3:0]  trap_cause,
    output logic        interupt,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_target
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSR_WAIT,
        ST_REDIRECT
    } state_e;

    state_e              state_q, state_d;
    logic                write_enable_q, write_enable_d;
    logic [ADDR_W-1:0]   write_address_q, write_address_d;
    logic [XLEN-1:0]     write_data_q, write_data_d;
    logic                retired_q, retired_d;
    logic                traped_q, traped_d;
    logic                mret_q, mret_d;
    logic [XLEN-1:0]     ecp_q, ecp_d;
    logic [CAUSE_W-1:0]  trap_cause_q, trap_cause_d;
    logic                interupt_q, interupt_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]     redirect_target_q, redirect_target_d;

    logic [XLEN-1:0]     csr_src_c, csr_wdata_c;
    logic                csr_op_bad_c, csr_wr_c, csr_illegal_c;
    logic                irq_take_c;
    logic [CAUSE_W-1:0]  irq_cause_c;
    logic                exc_take_c;
    logic [CAUSE_W-1:0]  exc_cause_c;

    // Zicsr source select, write qualification and new value
    always_comb begin
        csr_src_c    = in_csr_op[2] ? XLEN'(in_rs1_idx) : in_rs1_val;
        csr_op_bad_c = (in_csr_op[1:0] == 2'b00);
        csr_wr_c     = (in_csr_op[1:0] == 2'b01) || (!csr_op_bad_c && (in_rs1_idx != 5'd0));
        case (in_csr_op[1:0])
            2'b01:   csr_wdata_c = csr_src_c;
            2'b10:   csr_wdata_c = in_csr_old | csr_src_c;
            2'b11:   csr_wdata_c = in_csr_old & ~csr_src_c;
            default: csr_wdata_c = in_csr_old;
        endcase
        csr_illegal_c = in_is_csr && (csr_op_bad_c || (csr_wr_c && !in_csr_writeable));
    end

`ifdef TRAP_SEQUENCER_IRQ_EN
    always_comb begin
        irq_take_c = |irq;
        if (irq[2])      irq_cause_c = CAUSE_W'(11);
        else if (irq[1]) irq_cause_c = CAUSE_W'(3);
        else             irq_cause_c = CAUSE_W'(7);
    end
`else
    logic unused_irq;
    assign unused_irq  = ^irq;
    assign irq_take_c  = 1'b0;
    assign irq_cause_c = '0;
`endif

    // Synchronous exception priority
    always_comb begin
        exc_take_c  = 1'b1;
        exc_cause_c = '0;
        if (in_exc[3])                      exc_cause_c = CAUSE_W'(0);
        else if (in_exc[2] || csr_illegal_c) exc_cause_c = CAUSE_W'(2);
        else if (in_exc[1])                 exc_cause_c = CAUSE_W'(3);
        else if (in_exc[0])                 exc_cause_c = CAUSE_W'(11);
        else if (in_exc[4])                 exc_cause_c = CAUSE_W'(4);
        else if (in_exc[5])                 exc_cause_c = CAUSE_W'(6);
        else                                exc_take_c  = 1'b0;
    end

    always_comb begin
        state_d           = state_q;
        write_enable_d    = 1'b0;
        write_address_d   = write_address_q;
        write_data_d      = write_data_q;
        retired_d         = 1'b0;
        traped_d          = 1'b0;
        mret_d            = 1'b0;
        ecp_d             = ecp_q;
        trap_cause_d      = trap_cause_q;
        interupt_d        = 1'b0;
        redirect_valid_d  = redirect_valid_q;
        redirect_target_d = redirect_target_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (irq_take_c || exc_take_c) begin
                        traped_d          = 1'b1;
                        ecp_d             = in_pc;
                        trap_cause_d      = irq_take_c ? irq_cause_c : exc_cause_c;
                        interupt_d        = irq_take_c;
                        redirect_valid_d  = 1'b1;
                        redirect_target_d = trap_vector;
                        state_d           = ST_REDIRECT;
                    end else if (in_mret) begin
                        mret_d            = 1'b1;
                        retired_d         = 1'b1;
                        redirect_valid_d  = 1'b1;
                        redirect_target_d = mret_vector;
                        state_d           = ST_REDIRECT;
                    end else if (in_is_csr) begin
                        write_enable_d = csr_wr_c;
                        if (csr_wr_c) begin
                            write_address_d = in_csr_addr;
                            write_data_d    = csr_wdata_c;
                        end
                        retired_d = 1'b1;
                        state_d   = ST_CSR_WAIT;
                    end else begin
                        retired_d = 1'b1;
                    end
                end
            end
            // One bubble so updated interrupt-enable CSRs reach irq before the next accept
            ST_CSR_WAIT: state_d = ST_IDLE;
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            write_enable_q    <= 1'b0;
            write_address_q   <= '0;
            write_data_q      <= '0;
            retired_q         <= 1'b0;
            traped_q          <= 1'b0;
            mret_q            <= 1'b0;
            ecp_q             <= '0;
            trap_cause_q      <= '0;
            interupt_q        <= 1'b0;
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
        end else begin
            state_q           <= state_d;
            write_enable_q    <= write_enable_d;
            write_address_q   <= write_address_d;
            write_data_q      <= write_data_d;
            retired_q         <= retired_d;
            traped_q          <= traped_d;
            mret_q            <= mret_d;
            ecp_q             <= ecp_d;
            trap_cause_q      <= trap_cause_d;
            interupt_q        <= interupt_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_target_q <= redirect_target_d;
        end
    end

    assign in_ready        = (state_q == ST_IDLE);
    assign write_enable    = write_enable_q;
    assign write_address   = write_address_q;
    assign write_data      = write_data_q;
    assign retired         = retired_q;
    assign traped          = traped_q;
    assign mret            = mret_q;
    assign ecp             = ecp_q;
    assign trap_cause      = trap_cause_q;
    assign interupt        = interupt_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_target = redirect_target_q;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer
Writeback-stage sequencer driving the CSR unit's write and trap ports. Accepts one instruction per handshake, decides retire vs. trap vs. mret, and performs CSRRW/CSRRS/CSRRC read-modify-write. Arbitrates pending interrupts, then holds a redirect to fetch until acknowledged. It sits between the execute/writeback pipeline register and the CSR unit.
## Interface
- Parameters: none.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  high only in IDLE
- in_pc  in  32  instruction PC
- in_exc  in  6  {store_mis, load_mis, fetch_mis, illegal, ebreak, ecall}
- in_mret  in  1  instruction is MRET
- in_is_csr  in  1  instruction is Zicsr
- in_csr_op  in  3  funct3; bit2 selects zimm
- in_csr_addr  in  12  CSR address
- in_rs1_idx  in  5  rs1 index / zimm
- in_rs1_val  in  32  rs1 value
- in_csr_old  in  32  CSR value read at decode
- in_csr_writeable  in  1  decode writeable flag for in_csr_addr
- irq  in  3  {eip, sip, tip} from CSR unit
- trap_vector  in  32  mtvec
- mret_vector  in  32  mepc
- write_enable  out  1  CSR write strobe
- write_address  out  12  CSR write address
- write_data  out  32  CSR write data
- retired  out  1  instret increment pulse
- traped  out  1  trap pulse
- mret  out  1  mret pulse
- ecp  out  32  PC to save in mepc
- trap_cause  out  4  cause code
- interupt  out  1  cause is interrupt
- redirect_valid  out  1  fetch redirect request
- redirect_ready  in  1  fetch accepts redirect
- redirect_target  out  32  new fetch PC
## Operation
- States: IDLE, CSR_WAIT, REDIRECT. Accept = in_valid & in_ready (IDLE only).
- Priority at accept: interrupt (irq nonzero: eip cause 11, else sip 3, else tip 7; interupt=1) > fetch_mis 0 > illegal 2 (includes CSR illegal) > ebreak 3 > ecall 11 > load_mis 4 > store_mis 6 > mret > CSR > plain. Interrupt/exception: ecp=in_pc, no retire, no CSR write; goes to REDIRECT with target trap_vector.
- CSR src = op[2] ? {27'b0, in_rs1_idx} : in_rs1_val. op[1:0]: 01 data=src; 10 data=old|src; 11 data=old&~src; 00 → illegal.
- Write occurs for op 01 always, ops 10/11 only if in_rs1_idx≠0. A write with in_csr_writeable=0 is illegal (cause 2). Legal CSR: write pulse (if any) + retired, then CSR_WAIT for one cycle, then IDLE.
- MRET: mret pulse + retired; REDIRECT with target mret_vector.
- Plain instruction: retired pulse, stay IDLE.
- REDIRECT: redirect_valid held with stable target until redirect_ready; then IDLE next cycle.
## Timing
- Reset: state IDLE; write_enable, retired, traped, mret, interupt, redirect_valid = 0; write_address, write_data, ecp, redirect_target = 0; trap_cause = 0. Reset mid-REDIRECT drops redirect_valid the next cycle.
- Accept at cycle T → registered pulses (write_enable, retired, traped, mret) and ecp/trap_cause/interupt valid at T+1 for exactly one cycle. redirect_valid rises at T+1.
- Earliest next accept: T+1 for plain; T+2 for CSR (CSR_WAIT lets updated mstatus/mie gate irq); T+2 for trap/mret with redirect_ready already high.
- irq is sampled only at accept; changes in CSR_WAIT/REDIRECT are ignored until the next IDLE accept.
## Configuration
- TRAP_SEQUENCER_IRQ_EN: defined → irq arbitration as above. Undefined → irq ignored, interupt is tied to 0, and only exceptions trap.
## Test plan
- Plain instr pc=0x100 → T+1 retired=1 for one cycle; write_enable=0; in_ready high at T+1.
- CSRRS addr 0x340 old=0x0F rs1_idx=5 val=0xF0 → write 0x340/0xFF, retired; in_ready low one cycle. Same with rs1_idx=0 → no write, retired=1.
- CSRRW to 0xC00 with writeable=0, pc=0x200 → traped, cause 2, interupt 0, ecp=0x200; redirect to trap_vector 0x80 held 3 cycles while redirect_ready=0.
- irq=3'b111 with ecall at pc=0x300 → cause 11, interupt 1, ecp 0x300, retired 0; macro undefined → cause 11, interupt 0.
- MRET, mret_vector=0x404 → mret+retired pulse, redirect_target 0x404; reset asserted during REDIRECT → redirect_valid 0 next cycle, IDLE.
